// File: rtl/ping_pong_sched.sv
// Two-requester scheduler for a shared ping-pong counter: round-robin arbitration,
// bound validation, one-cycle load, and quantum-based preemption at the counter's lower bound.
module ping_pong_sched #(
    parameter int unsigned QUANTUM = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [3:0] cfg_max_a,
    input  logic [3:0] cfg_min_a,
    input  logic [3:0] cfg_max_b,
    input  logic [3:0] cfg_min_b,
    input  logic       flip_a,
    input  logic       flip_b,
    input  logic [3:0] cnt_out,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       err_a,
    output logic       err_b,
    output logic       busy,
    output logic       owner,
    output logic       cnt_rst_n,
    output logic       cnt_enable,
    output logic       cnt_flip,
    output logic [3:0] cnt_max,
    output logic [3:0] cnt_min
);

    // state | meaning
    // IDLE  | counter held in reset; arbitrate and validate the selected config
    // LOAD  | one cycle: bounds presented with counter still in reset, grant pulse
    // RUN   | counter enabled for the owner until release or preemption
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [7:0] QLAST = 8'(QUANTUM - 1);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;
    logic [7:0] qcnt_q, qcnt_d;
    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;
    logic       err_a_q, err_a_d;
    logic       err_b_q, err_b_d;
    logic       busy_q, busy_d;
    logic       cnt_rst_n_q, cnt_rst_n_d;
    logic       cnt_enable_q, cnt_enable_d;
    logic       cnt_flip_q, cnt_flip_d;
    logic [3:0] cnt_max_q, cnt_max_d;
    logic [3:0] cnt_min_q, cnt_min_d;

    logic       sel;
    logic [3:0] sel_max;
    logic [3:0] sel_min;
    logic       own_req;
    logic       oth_req;
    logic       own_flip;
    logic       leave_run;

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        owner_q      <= owner_d;
        last_owner_q <= last_owner_d;
        qcnt_q       <= qcnt_d;
        gnt_a_q      <= gnt_a_d;
        gnt_b_q      <= gnt_b_d;
        err_a_q      <= err_a_d;
        err_b_q      <= err_b_d;
        busy_q       <= busy_d;
        cnt_rst_n_q  <= cnt_rst_n_d;
        cnt_enable_q <= cnt_enable_d;
        cnt_flip_q   <= cnt_flip_d;
        cnt_max_q    <= cnt_max_d;
        cnt_min_q    <= cnt_min_d;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        qcnt_d       = qcnt_q;
        gnt_a_d      = 1'b0;
        gnt_b_d      = 1'b0;
        err_a_d      = 1'b0;
        err_b_d      = 1'b0;
        cnt_flip_d   = 1'b0;
        cnt_max_d    = cnt_max_q;
        cnt_min_d    = cnt_min_q;

        // On a tie, the requester that did not go last wins.
        sel       = (req_a && req_b) ? ~last_owner_q : req_b;
        sel_max   = sel ? cfg_max_b : cfg_max_a;
        sel_min   = sel ? cfg_min_b : cfg_min_a;
        own_req   = owner_q ? req_b : req_a;
        oth_req   = owner_q ? req_a : req_b;
        own_flip  = owner_q ? flip_b : flip_a;
        leave_run = !own_req ||
                    ((qcnt_q == QLAST) && oth_req && (cnt_out == cnt_min_q));

        case (state_q)
            S_IDLE: begin
                if (req_a || req_b) begin
                    if (sel_max > sel_min) begin
                        state_d   = S_LOAD;
                        owner_d   = sel;
                        cnt_max_d = sel_max;
                        cnt_min_d = sel_min;
                        gnt_a_d   = !sel;
                        gnt_b_d   = sel;
                    end else begin
                        // Rejected requester counts as served so the other wins the next tie.
                        last_owner_d = sel;
                        err_a_d      = !sel;
                        err_b_d      = sel;
                    end
                end
            end
            S_LOAD: begin
                qcnt_d  = 8'd0;
                state_d = S_RUN;
            end
            S_RUN: begin
                qcnt_d = (qcnt_q == QLAST) ? qcnt_q : qcnt_q + 8'd1;
                if (leave_run) begin
                    state_d      = S_IDLE;
                    last_owner_d = owner_q;
                end else begin
                    cnt_flip_d = own_flip;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rst) begin
            state_d      = S_IDLE;
            owner_d      = 1'b0;
            last_owner_d = 1'b1;
            qcnt_d       = 8'd0;
            gnt_a_d      = 1'b0;
            gnt_b_d      = 1'b0;
            err_a_d      = 1'b0;
            err_b_d      = 1'b0;
            cnt_flip_d   = 1'b0;
            cnt_max_d    = 4'd0;
            cnt_min_d    = 4'd0;
        end

        // Status outputs follow the state being entered so they stay registered.
        busy_d       = (state_d != S_IDLE);
        cnt_rst_n_d  = (state_d == S_RUN);
        cnt_enable_d = (state_d == S_RUN);
    end

    assign gnt_a      = gnt_a_q;
    assign gnt_b      = gnt_b_q;
    assign err_a      = err_a_q;
    assign err_b      = err_b_q;
    assign busy       = busy_q;
    assign owner      = owner_q;
    assign cnt_rst_n  = cnt_rst_n_q;
    assign cnt_enable = cnt_enable_q;
    assign cnt_flip   = cnt_flip_q;
    assign cnt_max    = cnt_max_q;
    assign cnt_min    = cnt_min_q;

endmodule

// File: tb/tb_ping_pong_sched.sv
// Directed testbench for ping_pong_sched; outputs sampled 1 time unit after each rising edge.
module tb_ping_pong_sched;

    logic       clk;
    logic       rst;
    logic       req_a, req_b;
    logic [3:0] cfg_max_a, cfg_min_a, cfg_max_b, cfg_min_b;
    logic       flip_a, flip_b;
    logic [3:0] cnt_out;
    logic       gnt_a, gnt_b, err_a, err_b, busy, owner;
    logic       cnt_rst_n, cnt_enable, cnt_flip;
    logic [3:0] cnt_max, cnt_min;

    int vecs = 0;
    int errs = 0;

    ping_pong_sched #(.QUANTUM(8)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b),
        .cfg_max_a(cfg_max_a), .cfg_min_a(cfg_min_a),
        .cfg_max_b(cfg_max_b), .cfg_min_b(cfg_min_b),
        .flip_a(flip_a), .flip_b(flip_b), .cnt_out(cnt_out),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .err_a(err_a), .err_b(err_b),
        .busy(busy), .owner(owner),
        .cnt_rst_n(cnt_rst_n), .cnt_enable(cnt_enable), .cnt_flip(cnt_flip),
        .cnt_max(cnt_max), .cnt_min(cnt_min)
    );

    // {busy, owner, gnt_a, gnt_b, err_a, err_b, cnt_rst_n, cnt_enable, cnt_flip, cnt_max, cnt_min}
    logic [16:0] obs;
    assign obs = {busy, owner, gnt_a, gnt_b, err_a, err_b,
                  cnt_rst_n, cnt_enable, cnt_flip, cnt_max, cnt_min};

    function automatic logic [16:0] ev(input logic b, input logic o, input logic ga,
                                       input logic gb, input logic ea, input logic eb,
                                       input logic rn, input logic en, input logic fl,
                                       input logic [3:0] mx, input logic [3:0] mn);
        return {b, o, ga, gb, ea, eb, rn, en, fl, mx, mn};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_a = 0; req_b = 0; flip_a = 0; flip_b = 0;
        cfg_max_a = 0; cfg_min_a = 0; cfg_max_b = 0; cfg_min_b = 0;
        cnt_out = 4'd5;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        logic [16:0] e;
        rst = 1;
        req_a = 1; cfg_max_a = 4'd9; cfg_min_a = 4'd2;
        req_b = 1; cfg_max_b = 4'd6; cfg_min_b = 4'd1;
        tick();
        e = ev(0,0,0,0,0,0,0,0,0,4'd0,4'd0);
        vecs++; if (obs !== e) begin errs++; $display("FAIL reset_state got %h exp %h", obs, e); end
        tick();
        vecs++; if (obs !== e) begin errs++; $display("FAIL reset_ignores_req got %h exp %h", obs, e); end
        clear_inputs();
        rst = 0;
        tick();
        vecs++; if (obs !== e) begin errs++; $display("FAIL idle_no_req got %h exp %h", obs, e); end
    endtask

    task automatic test_single_grant();
        logic [16:0] e;
        do_reset();
        req_a = 1; cfg_max_a = 4'd9; cfg_min_a = 4'd2;
        tick();
        e = ev(1,0,1,0,0,0,0,0,0,4'd9,4'd2);
        vecs++; if (obs !== e) begin errs++; $display("FAIL single_load got %h exp %h", obs, e); end
        tick();
        e = ev(1,0,0,0,0,0,1,1,0,4'd9,4'd2);
        vecs++; if (obs !== e) begin errs++; $display("FAIL single_run0 got %h exp %h", obs, e); end
        tick();
        vecs++; if (obs !== e) begin errs++; $display("FAIL single_run1 got %h exp %h", obs, e); end
        req_a = 0;
        tick();
        e = ev(0,0,0,0,0,0,0,0,0,4'd9,4'd2);
        vecs++; if (obs !== e) begin errs++; $display("FAIL single_release got %h exp %h", obs, e); end
    endtask

    task automatic test_round_robin();
        logic [16:0] e;
        do_reset();
        req_a = 1; cfg_max_a = 4'd9; cfg_min_a = 4'd2;
        req_b = 1; cfg_max_b = 4'd6; cfg_min_b = 4'd1;
        tick();
        e = ev(1,0,1,0,0,0,0,0,0,4'd9,4'd2);
        vecs++; if (obs !== e) begin errs++; $display("FAIL rr_first_a got %h exp %h", obs, e); end
        tick();
        e = ev(1,0,0,0,0,0,1,1,0,4'd9,4'd2);
        vecs++; if (obs !== e) begin errs++; $display("FAIL rr_a_run got %h exp %h", obs, e); end
        req_a = 0;
        tick();
        e = ev(0,0,0,0,0,0,0,0,0,4'd9,4'd2);
        vecs++; if (obs !== e) begin errs++; $display("FAIL rr_a_idle got %h exp %h", obs, e); end
        tick();
        e = ev(1,1,0,1,0,0,0,0,0,4'd6,4'd1);
        vecs++; if (obs !== e) begin errs++; $display("FAIL rr_gnt_b got %h exp %h", obs, e); end
        tick();
        e = ev(1,1,0,0,0,0,1,1,0,4'd6,4'd1);
        vecs++; if (obs !== e) begin errs++; $display("FAIL rr_b_run got %h exp %h", obs, e); end
        req_b = 0;
        tick();
        e = ev(0,1,0,0,0,0,0,0,0,4'd6,4'd1);
        vecs++; if (obs !== e) begin errs++; $display("FAIL rr_b_release got %h exp %h", obs, e); end
    endtask

    task automatic test_invalid_cfg();
        logic [16:0] e;
        do_reset();
        req_a = 1; cfg_max_a = 4'd3; cfg_min_a = 4'd3;
        tick();
        e = ev(0,0,0,0,1,0,0,0,0,4'd0,4'd0);
        vecs++; if (obs !== e) begin errs++; $display("FAIL inv_err_a got %h exp %h", obs, e); end
        req_a = 0;
        tick();
        e = ev(0,0,0,0,0,0,0,0,0,4'd0,4'd0);
        vecs++; if (obs !== e) begin errs++; $display("FAIL inv_err_pulse got %h exp %h", obs, e); end
        do_reset();
        req_a = 1; cfg_max_a = 4'd3; cfg_min_a = 4'd3;
        req_b = 1; cfg_max_b = 4'd7; cfg_min_b = 4'd0;
        tick();
        e = ev(0,0,0,0,1,0,0,0,0,4'd0,4'd0);
        vecs++; if (obs !== e) begin errs++; $display("FAIL inv_tie_err_a got %h exp %h", obs, e); end
        tick();
        e = ev(1,1,0,1,0,0,0,0,0,4'd7,4'd0);
        vecs++; if (obs !== e) begin errs++; $display("FAIL inv_then_gnt_b got %h exp %h", obs, e); end
        req_a = 0; req_b = 0;
        tick();
        e = ev(1,1,0,0,0,0,1,1,0,4'd7,4'd0);
        vecs++; if (obs !== e) begin errs++; $display("FAIL drop_in_load_run got %h exp %h", obs, e); end
        tick();
        e = ev(0,1,0,0,0,0,0,0,0,4'd7,4'd0);
        vecs++; if (obs !== e) begin errs++; $display("FAIL drop_in_load_release got %h exp %h", obs, e); end
    endtask

    task automatic test_preempt();
        logic [16:0] e;
        do_reset();
        req_a = 1; cfg_max_a = 4'd9; cfg_min_a = 4'd2;
        cfg_max_b = 4'd6; cfg_min_b = 4'd1;
        tick();
        e = ev(1,0,1,0,0,0,0,0,0,4'd9,4'd2);
        vecs++; if (obs !== e) begin errs++; $display("FAIL pre_load_a got %h exp %h", obs, e); end
        tick();
        e = ev(1,0,0,0,0,0,1,1,0,4'd9,4'd2);
        for (int k = 0; k < 10; k++) begin
            vecs++;
            if (obs !== e) begin
                errs++; $display("FAIL pre_run_cycle%0d got %h exp %h", k, obs, e);
            end
            if (k == 2) req_b = 1;
            cnt_out = (k == 7 || k == 8) ? 4'd5 : 4'd2;
            tick();
        end
        e = ev(0,0,0,0,0,0,0,0,0,4'd9,4'd2);
        vecs++; if (obs !== e) begin errs++; $display("FAIL pre_idle got %h exp %h", obs, e); end
        tick();
        e = ev(1,1,0,1,0,0,0,0,0,4'd6,4'd1);
        vecs++; if (obs !== e) begin errs++; $display("FAIL pre_gnt_b got %h exp %h", obs, e); end
    endtask

    task automatic test_flip();
        logic [16:0] e;
        do_reset();
        req_a = 1; cfg_max_a = 4'd9; cfg_min_a = 4'd2;
        tick();
        tick();
        flip_a = 1;
        tick();
        e = ev(1,0,0,0,0,0,1,1,1,4'd9,4'd2);
        vecs++; if (obs !== e) begin errs++; $display("FAIL flip_owner got %h exp %h", obs, e); end
        flip_a = 0;
        tick();
        e = ev(1,0,0,0,0,0,1,1,0,4'd9,4'd2);
        vecs++; if (obs !== e) begin errs++; $display("FAIL flip_one_cycle got %h exp %h", obs, e); end
        flip_b = 1;
        tick();
        vecs++; if (obs !== e) begin errs++; $display("FAIL flip_non_owner got %h exp %h", obs, e); end
        flip_b = 0;
        flip_a = 1; req_a = 0;
        tick();
        e = ev(0,0,0,0,0,0,0,0,0,4'd9,4'd2);
        vecs++; if (obs !== e) begin errs++; $display("FAIL flip_exit_cycle got %h exp %h", obs, e); end
        flip_a = 0;
    endtask

    task automatic test_reset_mid_run();
        logic [16:0] e;
        do_reset();
        req_a = 1; cfg_max_a = 4'd9; cfg_min_a = 4'd2;
        tick();
        tick();
        tick();
        e = ev(1,0,0,0,0,0,1,1,0,4'd9,4'd2);
        vecs++; if (obs !== e) begin errs++; $display("FAIL mid_pre_rst got %h exp %h", obs, e); end
        rst = 1;
        tick();
        e = ev(0,0,0,0,0,0,0,0,0,4'd0,4'd0);
        vecs++; if (obs !== e) begin errs++; $display("FAIL mid_rst_state got %h exp %h", obs, e); end
        tick();
        vecs++; if (obs !== e) begin errs++; $display("FAIL mid_rst_hold got %h exp %h", obs, e); end
        rst = 0;
        tick();
        e = ev(1,0,1,0,0,0,0,0,0,4'd9,4'd2);
        vecs++; if (obs !== e) begin errs++; $display("FAIL mid_regrant got %h exp %h", obs, e); end
        tick();
        e = ev(1,0,0,0,0,0,1,1,0,4'd9,4'd2);
        vecs++; if (obs !== e) begin errs++; $display("FAIL mid_regrant_run got %h exp %h", obs, e); end
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_invalid_cfg();
        test_preempt();
        test_flip();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
